// File: rtl/mem_req_fifo.sv
// In-order memory request buffer between the pipeline and the downstream memory/IO stage.
// Head entry is presented combinationally; sticky misalign/underflow error flags.
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_store,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          req_ready,
    input  logic          flush,
    output logic          load_to_bf,
    output logic          store_to_bf,
    output logic [31:0]   addr_to_bf,
    output logic [31:0]   wr_data,
    output logic          fifo_empty,
    input  logic          fifo_rd_en,
    output logic [CW-1:0] count,
    output logic          misalign,
    output logic          underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_store;
    logic [31:0]      mem_addr  [DEPTH];
    logic [31:0]      mem_wdata [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready depends only on registered count so it never loops through fifo_rd_en.
    assign req_ready  = (count < CW'(DEPTH)) && !flush;
    assign fifo_empty = (count == '0);
    assign push       = req_valid && req_ready;
    assign pop        = fifo_rd_en && !fifo_empty && !flush;

    assign load_to_bf  = !fifo_empty && !mem_store[rd_ptr];
    assign store_to_bf = !fifo_empty &&  mem_store[rd_ptr];
    assign addr_to_bf  = fifo_empty ? 32'h0 : mem_addr[rd_ptr];
    assign wr_data     = fifo_empty ? 32'h0 : mem_wdata[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            misalign  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            misalign  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && (req_addr[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
            if (fifo_rd_en && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage is not reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_store[wr_ptr] <= req_store;
            mem_addr[wr_ptr]  <= req_addr;
            mem_wdata[wr_ptr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_mem_req_fifo.sv
// Bench for mem_req_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_req_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_store = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          req_ready;
    logic          flush = 1'b0;
    logic          load_to_bf;
    logic          store_to_bf;
    logic [31:0]   addr_to_bf;
    logic [31:0]   wr_data;
    logic          fifo_empty;
    logic          fifo_rd_en = 1'b0;
    logic [CW-1:0] count;
    logic          misalign;
    logic          underflow;

    int vectors = 0;
    int miscompares = 0;

    mem_req_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .flush(flush),
        .load_to_bf(load_to_bf), .store_to_bf(store_to_bf), .addr_to_bf(addr_to_bf), .wr_data(wr_data),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .count(count),
        .misalign(misalign), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    logic m_mis = 1'b0;
    logic m_und = 1'b0;

    // Reference model: a request queue with the visible rules applied to it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_mis = 1'b0;
            m_und = 1'b0;
        end else if (flush) begin
            q.delete();
            m_mis = 1'b0;
            m_und = 1'b0;
        end else begin
            automatic int  sz = q.size();
            automatic logic do_push = req_valid && (sz < DEPTH);
            automatic logic do_pop  = fifo_rd_en && (sz > 0);
            if (fifo_rd_en && sz == 0) m_und = 1'b1;
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back('{st: req_store, a: req_addr, d: req_wdata});
                if (req_addr[1:0] != 2'b00) m_mis = 1'b1;
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_field(input int which);
        if (q.size() == 0) return 32'h0;
        case (which)
            0: return {31'h0, !q[0].st};
            1: return {31'h0, q[0].st};
            2: return q[0].a;
            default: return q[0].d;
        endcase
    endfunction

    always @(negedge clk) begin
        cmp("count",       32'(count),       32'(q.size()));
        cmp("fifo_empty",  32'(fifo_empty),  32'(q.size() == 0));
        cmp("req_ready",   32'(req_ready),   32'((q.size() < DEPTH) && !flush));
        cmp("load_to_bf",  32'(load_to_bf),  exp_field(0));
        cmp("store_to_bf", 32'(store_to_bf), exp_field(1));
        cmp("addr_to_bf",  addr_to_bf,       exp_field(2));
        cmp("wr_data",     wr_data,          exp_field(3));
        cmp("misalign",    32'(misalign),    32'(m_mis));
        cmp("underflow",   32'(underflow),   32'(m_und));
    end

    // Apply inputs for one clock edge, then return to idle just after that edge.
    task automatic step(input logic v, input logic s, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input logic f);
        req_valid  = v;
        req_store  = s;
        req_addr   = a;
        req_wdata  = d;
        fifo_rd_en = r;
        flush      = f;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        fifo_rd_en = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin
        #3;
        cmp("rst_empty", 32'(fifo_empty), 32'h1);
        cmp("rst_ready", 32'(req_ready), 32'h1);
        cmp("rst_addr", addr_to_bf, 32'h0);
        cmp("rst_store", 32'(store_to_bf), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single store, accepted on the first edge after reset release
        step(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
        cmp("st_store", 32'(store_to_bf), 32'h1);
        cmp("st_load", 32'(load_to_bf), 32'h0);
        cmp("st_addr", addr_to_bf, 32'h10);
        cmp("st_data", wr_data, 32'hDEAD_BEEF);
        cmp("st_count", 32'(count), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        cmp("st_pop_empty", 32'(fifo_empty), 32'h1);
        cmp("st_pop_count", 32'(count), 32'h0);

        // Fill with four loads, fifth dropped
        for (int i = 0; i < 4; i++) step(1, 0, 32'h400 + 32'(4 * i), 32'h0, 0, 0);
        cmp("fill_count", 32'(count), 32'h4);
        cmp("fill_ready", 32'(req_ready), 32'h0);
        cmp("fill_head", addr_to_bf, 32'h400);
        cmp("fill_load", 32'(load_to_bf), 32'h1);
        step(1, 0, 32'h500, 32'h0, 0, 0);
        cmp("drop_count", 32'(count), 32'h4);

        // Full with simultaneous pop: request refused, slot free next cycle
        step(1, 0, 32'h600, 32'h0, 1, 0);
        cmp("fullpop_count", 32'(count), 32'h3);
        cmp("fullpop_ready", 32'(req_ready), 32'h1);
        cmp("fullpop_head", addr_to_bf, 32'h404);
        step(1, 1, 32'h600, 32'h1234_5678, 0, 0);
        cmp("refill_count", 32'(count), 32'h4);
        for (int i = 0; i < 3; i++) begin
            cmp("order_head", addr_to_bf, 32'h404 + 32'(4 * i));
            step(0, 0, 0, 0, 1, 0);
        end
        cmp("order_last", addr_to_bf, 32'h600);
        cmp("order_last_st", 32'(store_to_bf), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        cmp("order_drained", 32'(fifo_empty), 32'h1);

        // Wrap: push/pop pairs with one entry resident
        step(1, 0, 32'h1000, 32'h0, 0, 0);
        for (int i = 1; i <= 10; i++) step(1, i[0], 32'h1000 + 32'(4 * i), 32'(i), 1, 0);
        cmp("wrap_head", addr_to_bf, 32'h1028);
        cmp("wrap_count", 32'(count), 32'h1);
        step(0, 0, 0, 0, 1, 0);

        // Flush beats concurrent push and pop
        for (int i = 0; i < 3; i++) step(1, 1, 32'h2000 + 32'(4 * i), 32'hA5, 0, 0);
        step(1, 0, 32'h3000, 32'h0, 1, 1);
        cmp("flush_count", 32'(count), 32'h0);
        cmp("flush_empty", 32'(fifo_empty), 32'h1);

        // Error flags
        step(1, 0, 32'h0000_0402, 32'h0, 0, 0);
        cmp("mis_set", 32'(misalign), 32'h1);
        cmp("mis_buffered", addr_to_bf, 32'h402);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        cmp("mis_hold", 32'(misalign), 32'h1);
        step(0, 0, 0, 0, 1, 0);
        cmp("und_set", 32'(underflow), 32'h1);
        cmp("und_count", 32'(count), 32'h0);
        step(0, 0, 0, 0, 0, 1);
        cmp("flush_mis", 32'(misalign), 32'h0);
        cmp("flush_und", 32'(underflow), 32'h0);

        // Asynchronous reset mid-cycle
        step(1, 1, 32'h44, 32'h55, 0, 0);
        step(1, 0, 32'h48, 32'h0, 0, 0);
        cmp("pre_rst_count", 32'(count), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("arst_count", 32'(count), 32'h0);
        cmp("arst_empty", 32'(fifo_empty), 32'h1);
        cmp("arst_store", 32'(store_to_bf), 32'h0);
        cmp("arst_addr", addr_to_bf, 32'h0);
        cmp("arst_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 32'h80, 32'h0, 0, 0);
        cmp("post_rst_count", 32'(count), 32'h1);
        cmp("post_rst_head", addr_to_bf, 32'h80);
        step(0, 0, 0, 0, 1, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            automatic logic [31:0] a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            step(($urandom_range(0, 99) < 55), 1'($urandom), a, $urandom,
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_req_fifo.md
MEM_REQ_FIFO -- requirements
Module: mem_req_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of request entries; power of two, 2..16.
REQ-002 Parameter: CW, 3, width of count output; equals log2(DEPTH)+1.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req_valid  input  1  pipeline presents a memory request this cycle.
REQ-006 Port: req_store  input  1  request type: 1 store, 0 load.
REQ-007 Port: req_addr  input  32  byte address of request.
REQ-008 Port: req_wdata  input  32  store data; ignored for loads.
REQ-009 Port: req_ready  output  1  block can accept a request this cycle.
REQ-010 Port: flush  input  1  discard all buffered requests.
REQ-011 Port: load_to_bf  output  1  head entry is a load.
REQ-012 Port: store_to_bf  output  1  head entry is a store.
REQ-013 Port: addr_to_bf  output  32  head entry address.
REQ-014 Port: wr_data  output  32  head entry store data.
REQ-015 Port: fifo_empty  output  1  no valid entry buffered.
REQ-016 Port: fifo_rd_en  input  1  downstream memory/register/IO stage consumed the head entry.
REQ-017 Port: count  output  CW  number of valid entries.
REQ-018 Port: misalign  output  1  sticky flag: a word request with req_addr[1:0] != 0 was accepted.
REQ-019 Port: underflow  output  1  sticky flag: fifo_rd_en seen while empty.

Function
REQ-020 Storage: DEPTH entries of {store bit, addr[31:0], wdata[31:0]}; write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH), count register.
REQ-021 req_ready = (count < DEPTH) and not flush; combinational from registered count only, never from fifo_rd_en.
REQ-022 Push: req_valid and req_ready -> entry written at write pointer, write pointer +1 at clock edge.
REQ-023 Pop: fifo_rd_en and not fifo_empty -> read pointer +1 at clock edge; entry contents not cleared.
REQ-024 Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop, never exceeds DEPTH nor drops below 0.
REQ-025 Full with pop same cycle: no push accepted (req_ready low); slot reusable next cycle.
REQ-026 Head outputs combinational from entry at read pointer, gated: load_to_bf = !fifo_empty & !store bit; store_to_bf = !fifo_empty & store bit; addr_to_bf and wr_data pass head fields, 0 when empty.
REQ-027 Head outputs hold stable every cycle until the pop edge; no request is presented twice or skipped.
REQ-028 fifo_empty = (count == 0); zero latency push-to-head: entry pushed at edge N visible on head outputs in cycle N+1 if FIFO was empty.
REQ-029 Order strictly first-in first-out; loads never bypass older stores.
REQ-030 Flush: synchronous, priority over push and pop; pointers and count to 0 next edge; concurrent req_valid dropped; concurrent fifo_rd_en ignored; clears misalign and underflow.
REQ-031 misalign set on push with req_addr[1:0] != 0; entry still buffered unchanged.
REQ-032 underflow set on fifo_rd_en while fifo_empty; pointers and count unchanged.

Reset
REQ-033 rst_n low: pointers, count, misalign, underflow = 0 immediately, independent of clk; hence fifo_empty=1, load_to_bf=store_to_bf=0, addr_to_bf=wr_data=0, req_ready=1.
REQ-034 Reset mid-operation discards all entries; storage array need not be reset.
REQ-035 First push accepted on first rising edge after rst_n deasserts.

Verification
REQ-036 Single store: push store addr 0x0000_0010 data 0xDEAD_BEEF -> next cycle store_to_bf=1, addr_to_bf=0x10, wr_data=0xDEADBEEF, count=1; fifo_rd_en one cycle -> fifo_empty=1, count=0.
REQ-037 Fill: 4 back-to-back loads addr 0x400,0x404,0x408,0x40C, no pops -> count=4, req_ready=0, 5th req_valid dropped; pops return 0x400..0x40C in order.
REQ-038 Full + simultaneous pop with req_valid -> count 4->3, req_ready=1 next cycle, new request stored after 0x40C; wrap: 10 push/pop pairs keep order.
REQ-039 Flush with count=3, req_valid and fifo_rd_en high -> count=0, fifo_empty=1 next edge, no entry stored or popped.
REQ-040 Errors: push addr 0x0000_0402 -> misalign=1 held; fifo_rd_en while empty -> underflow=1, count stays 0; flush clears both.
REQ-041 Async reset asserted mid-cycle with count=2 -> outputs take reset values before next edge; post-reset push works.
